// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
//
// Multiplexes NCH valid/ready input streams onto one registered output stream.
// MODE=0 picks the channel named by `sel`; MODE=1 uses a rotating round-robin
// pointer. A single output register holds one word. It can be drained and
// refilled in the same cycle, so a continuous stream runs without bubbles.
//
// Parameters
//   NCH    number of input channels (2..16)
//   WIDTH  data bits per channel
//   MODE   0 = explicit select, 1 = round-robin
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_data    channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel data valid
//   in_ready   per-channel accept strobe (combinational, at most one bit set)
//   sel        channel select, only used when MODE=0
//   out_data   registered selected word
//   out_valid  out_data holds an unconsumed word
//   out_ready  downstream accepts the word
//   out_ch     index of the channel that supplied out_data
// -----------------------------------------------------------------------------
module stream_mux_rr #(
  parameter  int NCH   = 4,
  parameter  int WIDTH = 8,
  parameter  int MODE  = 0,
  localparam int SW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SW-1:0]        sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SW-1:0]        out_ch
);

  // Valid vector padded to the full select range: indices >= NCH read as 0,
  // so an out-of-range select or wrapped index can never grant anything.
  localparam int NPAD = 1 << SW;
  localparam int SWP  = SW + 1;

  logic [NPAD-1:0]  valid_pad_s;
  logic             space_s;
  logic [SWP-1:0]   rr_idx_s;
  logic [SW-1:0]    rr_grant_s;
  logic             rr_found_s;
  logic             sel_found_s;
  logic [SW-1:0]    grant_s;
  logic             grant_vld_s;
  logic             xfer_s;
  logic [WIDTH-1:0] grant_data_s;
  logic [NCH-1:0]   in_ready_s;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SW-1:0]    out_ch_q,   out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SW-1:0]    ptr_q,      ptr_d;

  // (v + 1) mod NCH, valid for NCH that is not a power of two.
  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    if (v == SW'(NCH - 1)) begin
      r = '0;
    end else begin
      r = v + SW'(1);
    end
    return r;
  endfunction

  // (base + k) mod NCH, where base < NCH and k < NCH.
  function automatic logic [SWP-1:0] wrap_add(input logic [SW-1:0] base, input int k);
    logic [SWP-1:0] s;
    s = {1'b0, base} + SWP'(k);
    if (s >= SWP'(NCH)) begin
      s = s - SWP'(NCH);
    end else begin
      s = s;
    end
    return s;
  endfunction

  // Zero-extend in_valid to the padded select range.
  always_comb begin
    valid_pad_s          = '0;
    valid_pad_s[NCH-1:0] = in_valid;
  end

  // Round-robin search: first valid channel at ptr, ptr+1, ... with wrap.
  always_comb begin
    rr_found_s = 1'b0;
    rr_grant_s = '0;
    rr_idx_s   = '0;
    for (int k = 0; k < NCH; k++) begin
      rr_idx_s = wrap_add(ptr_q, k);
      if (!rr_found_s && valid_pad_s[rr_idx_s[SW-1:0]]) begin
        rr_found_s = 1'b1;
        rr_grant_s = rr_idx_s[SW-1:0];
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Explicit select: the padded vector makes sel >= NCH grant nothing.
  always_comb begin
    sel_found_s = valid_pad_s[sel];
  end

  // Grant selection, space and transfer qualification (never uses in_data).
  always_comb begin
    grant_s     = (MODE == 1) ? rr_grant_s : sel;
    grant_vld_s = (MODE == 1) ? rr_found_s : sel_found_s;
    space_s     = !out_valid_q || out_ready;
    xfer_s      = grant_vld_s && space_s && !rst;
  end

  // One-hot ready strobe for the granted channel, only when a transfer occurs.
  always_comb begin
    in_ready_s = '0;
    for (int i = 0; i < NCH; i++) begin
      in_ready_s[i] = xfer_s && (grant_s == SW'(i));
    end
  end

  // AND-OR data mux of the granted channel.
  always_comb begin
    grant_data_s = '0;
    for (int i = 0; i < NCH; i++) begin
      grant_data_s = grant_data_s
                   | ({WIDTH{grant_s == SW'(i)}} & in_data[i*WIDTH +: WIDTH]);
    end
  end

  // Next-state: load on transfer (drain+fill keeps valid high), clear on drain.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer_s) begin
      out_data_d  = grant_data_s;
      out_ch_d    = grant_s;
      out_valid_d = 1'b1;
      ptr_d       = (MODE == 1) ? wrap_inc(grant_s) : ptr_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

  stream_mux_rr_chk #(
    .NCH   (NCH),
    .WIDTH (WIDTH),
    .SW    (SW)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .in_ready  (in_ready_s),
    .out_valid (out_valid_q),
    .out_ready (out_ready),
    .out_data  (out_data_q),
    .out_ch    (out_ch_q)
  );

endmodule

// -----------------------------------------------------------------------------
// stream_mux_rr_chk
//
// Protocol properties of stream_mux_rr: single grant, no accept without space
// or during reset, and a stalled output word stays stable.
// -----------------------------------------------------------------------------
module stream_mux_rr_chk #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  parameter int SW    = 2
) (
  input logic             clk,
  input logic             rst,
  input logic [NCH-1:0]   in_ready,
  input logic             out_valid,
  input logic             out_ready,
  input logic [WIDTH-1:0] out_data,
  input logic [SW-1:0]    out_ch
);

  a_ready_onehot0: assert property (@(posedge clk) $onehot0(in_ready));

  a_ready_no_space: assert property (@(posedge clk)
    (out_valid && !out_ready) |-> (in_ready == '0));

  a_ready_in_reset: assert property (@(posedge clk) rst |-> (in_ready == '0));

  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_ch)));

endmodule

// File: tb/tb_stream_mux_rr.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_rr
//
// Directed bench with two instances: A = round-robin (NCH=4) and
// B = explicit select (NCH=3). Accepted output words are checked by
// per-instance scoreboards. Cycle-level properties (ready, valid, hold,
// reset) are checked directly in the stimulus flow.
// -----------------------------------------------------------------------------
module tb_stream_mux_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [31:0] a_in_data;
  logic [3:0]  a_in_valid, a_in_ready;
  logic [1:0]  a_sel, a_out_ch;
  logic [7:0]  a_out_data;
  logic        a_out_valid, a_out_ready;

  logic [23:0] b_in_data;
  logic [2:0]  b_in_valid, b_in_ready;
  logic [1:0]  b_sel, b_out_ch;
  logic [7:0]  b_out_data;
  logic        b_out_valid, b_out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  stream_mux_rr #(.NCH(4), .WIDTH(8), .MODE(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ch(a_out_ch)
  );

  stream_mux_rr #(.NCH(3), .WIDTH(8), .MODE(0)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ch(b_out_ch)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for instance A: one pop per accepted word.
  always @(negedge clk) begin
    exp_t e;
    if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
      if (qa.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_sb_unexpected: got ch %0d data %0h expected no word", a_out_ch, a_out_data);
      end else begin
        e = qa.pop_front();
        chk("a_sb_ch", 32'(a_out_ch), 32'(e.ch));
        chk("a_sb_data", 32'(a_out_data), 32'(e.data));
      end
    end
  end

  // Scoreboard monitor for instance B.
  always @(negedge clk) begin
    exp_t e;
    if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
      if (qb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_sb_unexpected: got ch %0d data %0h expected no word", b_out_ch, b_out_data);
      end else begin
        e = qb.pop_front();
        chk("b_sb_ch", 32'(b_out_ch), 32'(e.ch));
        chk("b_sb_data", 32'(b_out_data), 32'(e.data));
      end
    end
  end

  initial begin
    rst         = 1'b1;
    a_in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
    a_in_valid  = 4'b1111;
    a_out_ready = 1'b1;
    a_sel       = 2'd0;
    b_in_data   = {8'hA5, 8'h5B, 8'hC3};
    b_in_valid  = 3'b000;
    b_out_ready = 1'b0;
    b_sel       = 2'd0;

    // Reset state, ready suppressed while rst is high
    step();
    @(negedge clk);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    chk("rst_out_ch", 32'(a_out_ch), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd0);
    chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);

    // A: all channels valid, round-robin 0,1,2,3,0 without bubbles
    step();
    rst = 1'b0;
    qa.push_back({2'd0, 8'h10});
    qa.push_back({2'd1, 8'h21});
    qa.push_back({2'd2, 8'h32});
    qa.push_back({2'd3, 8'h43});
    qa.push_back({2'd0, 8'h10});
    @(negedge clk);
    chk("rr_first_ready", 32'(a_in_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 4) a_in_valid = 4'b0000;
      @(negedge clk);
      chk("rr_stream_valid", 32'(a_out_valid), 32'd1);
    end
    step();
    @(negedge clk);
    chk("drain_valid", 32'(a_out_valid), 32'd0);
    chk("drain_data_hold", 32'(a_out_data), 32'h10);
    chk("drain_ch_hold", 32'(a_out_ch), 32'd0);

    // A: in_valid=1010 from ptr=0 grants 1,3,1
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_in_valid = 4'b1010;
    qa.push_back({2'd1, 8'h21});
    qa.push_back({2'd3, 8'h43});
    qa.push_back({2'd1, 8'h21});
    @(negedge clk);
    chk("sparse_ready_1", 32'(a_in_ready), 32'h2);
    step();
    @(negedge clk);
    chk("sparse_ready_3", 32'(a_in_ready), 32'h8);
    step();
    @(negedge clk);
    chk("sparse_ready_1b", 32'(a_in_ready), 32'h2);
    step();
    a_in_valid = 4'b0000;
    @(negedge clk);
    chk("sparse_last_ch", 32'(a_out_ch), 32'd1);
    step();

    // A: park a word with ptr=2, stall, then reset mid-stream
    a_in_valid  = 4'b0010;
    a_out_ready = 1'b0;
    @(negedge clk);
    chk("park_ready", 32'(a_in_ready), 32'h2);
    step();
    a_in_valid = 4'b1111;
    @(negedge clk);
    chk("stall_ready_zero", 32'(a_in_ready), 32'd0);
    chk("stall_valid", 32'(a_out_valid), 32'd1);
    chk("stall_ch", 32'(a_out_ch), 32'd1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("stall_data_hold", 32'(a_out_data), 32'h21);
    chk("rst_mid_ready", 32'(a_in_ready), 32'd0);
    step();
    rst = 1'b0;
    a_out_ready = 1'b1;
    qa.push_back({2'd0, 8'h10});
    @(negedge clk);
    chk("midrst_valid", 32'(a_out_valid), 32'd0);
    chk("midrst_data", 32'(a_out_data), 32'd0);
    chk("midrst_ch", 32'(a_out_ch), 32'd0);
    chk("midrst_ptr0_grant", 32'(a_in_ready), 32'h1);
    step();
    a_in_valid = 4'b0000;
    @(negedge clk);
    step();

    // B: sel=2, 0xA5 held for 3 stalled cycles, no overwrite
    b_sel       = 2'd2;
    b_in_valid  = 3'b100;
    b_out_ready = 1'b0;
    qb.push_back({2'd2, 8'hA5});
    @(negedge clk);
    chk("sel2_ready", 32'(b_in_ready), 32'h4);
    for (int k = 0; k < 3; k++) begin
      step();
      b_in_data[23:16] = 8'h77;
      @(negedge clk);
      chk("sel2_hold_ready", 32'(b_in_ready), 32'd0);
      chk("sel2_hold_data", 32'(b_out_data), 32'hA5);
      chk("sel2_hold_valid", 32'(b_out_valid), 32'd1);
    end
    step();
    b_out_ready = 1'b1;
    b_in_valid  = 3'b000;
    @(negedge clk);
    step();
    b_in_data[23:16] = 8'hA5;
    @(negedge clk);
    chk("sel2_drained", 32'(b_out_valid), 32'd0);

    // B: sel=3 with NCH=3 grants nothing
    step();
    b_sel      = 2'd3;
    b_in_valid = 3'b111;
    @(negedge clk);
    chk("sel_oor_ready", 32'(b_in_ready), 32'd0);
    chk("sel_oor_valid", 32'(b_out_valid), 32'd0);
    step();
    @(negedge clk);
    chk("sel_oor_valid2", 32'(b_out_valid), 32'd0);

    // B: full output replaced in the same cycle it drains
    step();
    b_sel       = 2'd0;
    b_in_valid  = 3'b001;
    b_out_ready = 1'b0;
    qb.push_back({2'd0, 8'hC3});
    @(negedge clk);
    chk("fill_ready", 32'(b_in_ready), 32'h1);
    step();
    b_out_ready     = 1'b1;
    b_in_data[7:0]  = 8'h3C;
    qb.push_back({2'd0, 8'h3C});
    @(negedge clk);
    chk("refill_ready", 32'(b_in_ready), 32'h1);
    chk("refill_valid", 32'(b_out_valid), 32'd1);
    step();
    b_in_valid = 3'b000;
    @(negedge clk);
    chk("refill_no_bubble", 32'(b_out_valid), 32'd1);
    chk("refill_data", 32'(b_out_data), 32'h3C);
    step();
    @(negedge clk);
    chk("refill_drained", 32'(b_out_valid), 32'd0);

    chk("a_sb_empty", 32'(qa.size()), 32'd0);
    chk("b_sb_empty", 32'(qb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The block SHALL have parameter NCH, default 4, number of input channels (2..16).
REQ-002 The block SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-003 The block SHALL have parameter MODE, default 0: 0 = explicit select, 1 = round-robin.
REQ-004 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_valid  input  NCH  per-channel data-valid.
REQ-008 The block SHALL have port in_ready  output  NCH  per-channel accept strobe, combinational.
REQ-009 The block SHALL have port sel  input  SW=max(1,clog2(NCH))  channel select, used only when MODE=0.
REQ-010 The block SHALL have port out_data  output  WIDTH  registered selected data.
REQ-011 The block SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-012 The block SHALL have port out_ready  input  1  downstream accepts the word.
REQ-013 The block SHALL have port out_ch  output  SW  index of the channel that supplied out_data.

Function
REQ-014 The block SHALL hold one output word in a register; space = !out_valid | out_ready.
REQ-015 A transfer on channel i SHALL occur in a cycle where in_valid[i] & in_ready[i]; out_data/out_ch/out_valid update on the next edge (latency 1).
REQ-016 At most one in_ready bit SHALL be high in any cycle; in_ready SHALL be all-zero when space is 0.
REQ-017 MODE=0: grant = sel when sel < NCH and in_valid[sel]; sel >= NCH grants nothing and does not alter state.
REQ-018 MODE=1: grant = first i with in_valid[i], searching ptr, ptr+1, ... wrapping NCH-1 -> 0.
REQ-019 MODE=1: on each transfer ptr SHALL become (grant+1) mod NCH; ptr unchanged in cycles with no transfer.
REQ-020 Arbitration SHALL be recomputed every cycle; a non-granted valid is not latched or queued.
REQ-021 Simultaneous drain and fill (out_valid & out_ready & transfer) SHALL load the new word with out_valid staying 1; no bubble.
REQ-022 Drain without fill SHALL clear out_valid next edge; out_data and out_ch hold their last value.
REQ-023 While out_valid & !out_ready, out_data and out_ch SHALL remain stable.
REQ-024 in_ready SHALL NOT depend on in_data; it may depend on in_valid, sel, ptr, out_valid, out_ready.
REQ-025 Behaviour SHALL be identical for NCH a power of two and not (e.g. NCH=3: ptr wraps 2 -> 0).

Reset
REQ-026 While rst is high at a clock edge: out_valid=0, out_data=0, out_ch=0, ptr=0.
REQ-027 In a cycle with rst high, in_ready SHALL be all-zero and no transfer SHALL be counted.
REQ-028 Reset asserted mid-stream SHALL discard the held word; first grant after release uses ptr=0.

Verification
REQ-029 MODE=1, NCH=4, all in_valid=1, out_ready=1 constant -> out_ch sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1 from cycle 2.
REQ-030 MODE=1, in_valid=4'b1010, ptr=0 -> grant 1, then 3, then 1; channels 0 and 2 never granted.
REQ-031 MODE=0, sel=2, in_data ch2=8'hA5, out_ready=0 for 3 cycles -> out_data=8'hA5 held, in_ready=0 after first transfer, no overwrite.
REQ-032 MODE=0, NCH=3, sel=3 with all in_valid=1 -> in_ready=0, out_valid stays 0.
REQ-033 Full output with out_ready=1 and in_valid[0]=1 same cycle -> word replaced next edge, out_valid never drops.
REQ-034 rst pulsed 1 cycle while out_valid=1, ptr=2 -> next cycle out_valid=0, out_data=0, out_ch=0; next grant starts search at channel 0.
